// File: rtl/reg_file_pkg.sv
// reg_file_pkg
//   Shared constants and types for the 16-bit processor register file.
//   DATA_W / ADDR_W set the default register width and address width.
//   reg_addr_t is also used by the decode and hazard logic, so every
//   register specifier in the datapath has the same width.
//   Port summary: none (package only).
package reg_file_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 3;
    localparam int NUM_REGS = 1 << ADDR_W;

    typedef logic [ADDR_W-1:0] reg_addr_t;
    typedef logic [DATA_W-1:0] reg_data_t;

endpackage

// File: rtl/reg_read_mux.sv
// reg_read_mux
//   A 2**ADDR_W : 1 multiplexer, DATA_W bits wide, that serves one
//   combinational read port of the register file. The register contents
//   come in on one flattened vector: register i occupies bits
//   [i*DATA_W +: DATA_W].
//   Ports:
//     sel       in  ADDR_W             register address to read
//     regs_flat in  DATA_W*2**ADDR_W   all register contents, flattened
//     rd_data   out DATA_W             selected register value
module reg_read_mux
    import reg_file_pkg::*;
#(
    parameter int DATA_W = reg_file_pkg::DATA_W,
    parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
    input  logic [ADDR_W-1:0]                 sel,
    input  logic [(DATA_W<<ADDR_W)-1:0]       regs_flat,
    output logic [DATA_W-1:0]                 rd_data
);

    localparam int NREGS = 1 << ADDR_W;

    always_comb begin
        rd_data = '0;
        for (int i = 0; i < NREGS; i++) begin
            if (sel == i[ADDR_W-1:0]) begin
                rd_data = regs_flat[i*DATA_W +: DATA_W];
            end
        end
    end

endmodule

// File: rtl/reg_file.sv
// reg_file
//   General-purpose register file for the pipelined 16-bit datapath:
//   2**ADDR_W registers of DATA_W bits, two combinational read ports and
//   one write port that writes on every rising clock edge (there is no
//   write enable, so callers park A3/D3 at a harmless value). Reads have
//   no bypass from D3. Forwarding is left to the pipeline.
//   Ports:
//     clk    in   1       system clock, writes on the rising edge
//     A1     in   ADDR_W  read address, port 1
//     A2     in   ADDR_W  read address, port 2
//     A3     in   ADDR_W  write address
//     D3     in   DATA_W  write data
//     D1     out  DATA_W  R[A1]
//     D2     out  DATA_W  R[A2]
//     rst_n  in   1       asynchronous active-low reset, clears all registers
module reg_file
    import reg_file_pkg::*;
#(
    parameter int DATA_W = reg_file_pkg::DATA_W,
    parameter int ADDR_W = reg_file_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic [ADDR_W-1:0] A1,
    input  logic [ADDR_W-1:0] A2,
    input  logic [ADDR_W-1:0] A3,
    input  logic [DATA_W-1:0] D3,
    output logic [DATA_W-1:0] D1,
    output logic [DATA_W-1:0] D2,
    input  logic              rst_n
);

    localparam int NREGS = 1 << ADDR_W;

    logic [DATA_W-1:0]         regs_q [NREGS];
    logic [DATA_W-1:0]         regs_d [NREGS];
    logic [(DATA_W<<ADDR_W)-1:0] regs_flat;

    // Write decoder: exactly one register takes D3 each cycle. The others
    // hold their value.
    always_comb begin
        for (int i = 0; i < NREGS; i++) begin
            regs_d[i] = (A3 == i[ADDR_W-1:0]) ? D3 : regs_q[i];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NREGS; i++) begin
                regs_q[i] <= regs_d[i];
            end
        end
    end

    always_comb begin
        regs_flat = '0;
        for (int i = 0; i < NREGS; i++) begin
            regs_flat[i*DATA_W +: DATA_W] = regs_q[i];
        end
    end

    reg_read_mux #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_read_mux_1 (
        .sel      (A1),
        .regs_flat(regs_flat),
        .rd_data  (D1)
    );

    reg_read_mux #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) u_read_mux_2 (
        .sel      (A2),
        .regs_flat(regs_flat),
        .rd_data  (D2)
    );

endmodule

// File: tb/tb_reg_file.sv
// tb_reg_file
//   Self-checking bench for reg_file. The reference is a plain array of
//   register values. It is updated once per rising edge, only while reset
//   is released, and cleared whenever reset is asserted.
module tb_reg_file;
    import reg_file_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n;
    reg_addr_t a1, a2, a3;
    reg_data_t d3, d1, d2;

    reg_data_t model [NUM_REGS];
    int passCount  = 0;
    int checkCount = 0;

    reg_file #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .clk  (clk),
        .A1   (a1),
        .A2   (a2),
        .A3   (a3),
        .D3   (d3),
        .D1   (d1),
        .D2   (d2),
        .rst_n(rst_n)
    );

    always #5 clk = ~clk;

    // Drive all address/data inputs, then let the combinational reads settle.
    task automatic applyStimulus(input reg_addr_t ra1, input reg_addr_t ra2,
                                 input reg_addr_t wa, input reg_data_t wd);
        a1 = ra1;
        a2 = ra2;
        a3 = wa;
        d3 = wd;
        #1;
    endtask

    task automatic checkOne(input string tag, input reg_data_t obs, input reg_data_t exp);
        checkCount++;
        assert (obs === exp) passCount++;
        else $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Compare both read ports against the reference array.
    task automatic checkOutput(input string tag);
        checkOne({tag, "/D1"}, d1, model[a1]);
        checkOne({tag, "/D2"}, d2, model[a2]);
    endtask

    // Advance one rising edge and apply the unconditional write to the model.
    task automatic clockEdge();
        @(posedge clk);
        if (rst_n) model[a3] = d3;
        #1;
    endtask

    task automatic clearModel();
        foreach (model[i]) model[i] = '0;
    endtask

    // Read every register through both ports, expecting zero.
    task automatic checkAllZero(input string tag);
        for (int i = 0; i < NUM_REGS; i++) begin
            applyStimulus(reg_addr_t'(i), reg_addr_t'(NUM_REGS - 1 - i), a3, d3);
            checkOne({tag, "/D1"}, d1, 16'h0000);
            checkOne({tag, "/D2"}, d2, 16'h0000);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        a1 = '0; a2 = '0; a3 = '0; d3 = '0;
        clearModel();

        // Reset holds every register at zero before any clock edge.
        #2;
        applyStimulus(reg_addr_t'(3), reg_addr_t'(5), reg_addr_t'(3), 16'hDEAD);
        checkOne("rst_async/D1", d1, 16'h0000);
        checkOne("rst_async/D2", d2, 16'h0000);

        // An edge while in reset must not perform the pending write.
        clockEdge();
        checkOne("rst_nowrite/D1", d1, 16'h0000);

        // Release between edges, parked write of zero to R0.
        rst_n = 1'b1;
        applyStimulus('0, '0, '0, 16'h0000);
        clockEdge();
        checkAllZero("rst_release");

        // Basic write then read.
        applyStimulus('0, '0, reg_addr_t'(0), 16'hAAAA);
        clockEdge();
        checkOne("basic/D1", d1, 16'hAAAA);

        // Overwrite the same register on consecutive edges.
        applyStimulus('0, '0, reg_addr_t'(4), 16'hAAAA);
        clockEdge();
        applyStimulus('0, '0, reg_addr_t'(4), 16'h0001);
        clockEdge();
        applyStimulus('0, reg_addr_t'(4), reg_addr_t'(4), 16'h0001);
        checkOne("overwrite/D2", d2, 16'h0001);

        // Address/data skew.
        applyStimulus('0, '0, reg_addr_t'(6), 16'h0001);
        clockEdge();
        applyStimulus('0, '0, reg_addr_t'(6), 16'h0005);
        clockEdge();
        applyStimulus('0, '0, reg_addr_t'(2), 16'h0005);
        clockEdge();
        applyStimulus('0, '0, reg_addr_t'(2), 16'h0007);
        clockEdge();

        // Dual reads, same and different registers (no edge in between).
        applyStimulus(reg_addr_t'(2), reg_addr_t'(2), reg_addr_t'(2), 16'h0007);
        checkOne("dual_same/D1", d1, 16'h0007);
        checkOne("dual_same/D2", d2, 16'h0007);
        applyStimulus(reg_addr_t'(0), reg_addr_t'(6), reg_addr_t'(2), 16'h0007);
        checkOne("dual_diff/D1", d1, 16'hAAAA);
        checkOne("dual_diff/D2", d2, 16'h0005);

        // Read-during-write: old value before the edge, new value after.
        applyStimulus(reg_addr_t'(5), reg_addr_t'(5), reg_addr_t'(5), 16'h1234);
        checkOne("rdw_before/D1", d1, 16'h0000);
        clockEdge();
        checkOne("rdw_after/D1", d1, 16'h1234);
        checkOne("rdw_after/D2", d2, 16'h1234);
        checkOutput("model_sync");

        // Reset pulse mid-cycle clears everything with no clock edge.
        rst_n = 1'b0;
        clearModel();
        #1;
        checkAllZero("rst_mid");
        applyStimulus(reg_addr_t'(5), reg_addr_t'(5), reg_addr_t'(5), 16'hBEEF);
        clockEdge();
        checkOne("rst_mid_nowrite/D1", d1, 16'h0000);
        rst_n = 1'b1;

        // Randomized traffic against the reference array.
        for (int n = 0; n < 300; n++) begin
            applyStimulus(reg_addr_t'($urandom), reg_addr_t'($urandom),
                          reg_addr_t'($urandom), reg_data_t'($urandom));
            checkOutput("rnd_pre");
            if ($urandom_range(0, 39) == 0) begin
                rst_n = 1'b0;
                clearModel();
                #1;
                checkOutput("rnd_rst");
                rst_n = 1'b1;
            end
            clockEdge();
            checkOutput("rnd_post");
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
